dmi_core_req_buffer: RTL and testbench

- Core-clock stage directly downstream of the JTAG-to-core synchronizer.
- Consumes its single-cycle reg_en / reg_wr_en pulses and captures the quasi-static DMI address and write data.
- Issues exactly one request to the debug module over a valid/ready channel, then waits for the response.
- Returns read data and busy/error status to the JTAG-side DMI register.

---
 rtl/dmi_core_req_buffer.sv | 162 ++++++++++++++++
 tb/tb_dmi_core_req_buffer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_core_req_buffer.sv
// dmi_core_req_buffer
// Core-clock stage behind the JTAG-to-core synchronizer. It turns one
// reg_en pulse into exactly one valid/ready request to the debug module,
// then waits for the single-cycle response. Read data and sticky error
// status go back to the JTAG-side DMI register.
//
// Optional build macro: DMI_REQ_TIMEOUT_EN
//   When defined, a 16-bit cycle counter aborts a request that has had no
//   handshake or response after TIMEOUT_CYCLES cycles. When undefined,
//   REQ and RSP wait indefinitely and TIMEOUT_CYCLES is only range-checked.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no access outstanding, next reg_en is captured
// REQ   | dm_req_valid high, payload held until dm_req_ready
// RSP   | request accepted, waiting for dm_rsp_valid
module dmi_core_req_buffer #(
  parameter int unsigned AW             = 7,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          reg_en,
  input  logic          reg_wr_en,
  input  logic [AW-1:0] reg_addr,
  input  logic [DW-1:0] reg_wdata,
  output logic          dm_req_valid,
  input  logic          dm_req_ready,
  output logic          dm_req_we,
  output logic [AW-1:0] dm_req_addr,
  output logic [DW-1:0] dm_req_wdata,
  input  logic          dm_rsp_valid,
  input  logic [DW-1:0] dm_rsp_rdata,
  input  logic          dm_rsp_err,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [1:0]    err_status,
  input  logic          err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t     state;
  logic       req_hs;
  logic       rsp_hit;
  logic       tmo;
  logic       abort;
  logic [1:0] err_set;

  // Out-of-range timeout values are rejected at elaboration in every build.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dmi_core_req_buffer: TIMEOUT_CYCLES must be 1..65535");
  end

`ifdef DMI_REQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_TC = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt;

  // Cycle counter: held at zero in IDLE so it starts from zero on REQ entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign tmo = (state != IDLE) && (tmo_cnt == TIMEOUT_TC);
`else
  assign tmo = 1'b0;
`endif

  assign req_hs  = (state == REQ) && dm_req_ready;
  assign rsp_hit = (state == RSP) && dm_rsp_valid;
  // A handshake or response in the terminal cycle beats the timeout.
  assign abort   = tmo && !req_hs && !rsp_hit;

  // Error events this cycle: [0] DM error or abort, [1] overrun.
  always_comb begin
    err_set = 2'b00;
    if ((state != IDLE) && reg_en) begin
      err_set[1] = 1'b1;
    end
    if (rsp_hit && dm_rsp_err) begin
      err_set[0] = 1'b1;
    end
    if (abort) begin
      err_set[0] = 1'b1;
    end
  end

  // Sticky error bits; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_status <= 2'b00;
    end else begin
      err_status <= (err_clr ? 2'b00 : err_status) | err_set;
    end
  end

  // Request/response sequencer with registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dm_req_valid <= 1'b0;
      dm_req_we    <= 1'b0;
      dm_req_addr  <= '0;
      dm_req_wdata <= '0;
      rd_data      <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reg_en) begin
            dm_req_addr  <= reg_addr;
            dm_req_wdata <= reg_wdata;
            dm_req_we    <= reg_wr_en;
            dm_req_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (req_hs) begin
            dm_req_valid <= 1'b0;
            state        <= RSP;
          end else if (abort) begin
            dm_req_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        RSP: begin
          if (rsp_hit) begin
            if (!dm_req_we && !dm_rsp_err) begin
              rd_data <= dm_rsp_rdata;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          dm_req_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_core_req_buffer.sv
// Bench for dmi_core_req_buffer: directed plan items, then randomized
// transactions checked against a transaction-level model of the buffer.
module tb_dmi_core_req_buffer;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          reg_en, reg_wr_en;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          dm_req_valid, dm_req_ready, dm_req_we;
  logic [AW-1:0] dm_req_addr;
  logic [DW-1:0] dm_req_wdata;
  logic          dm_rsp_valid, dm_rsp_err;
  logic [DW-1:0] dm_rsp_rdata;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [1:0]    err_status;
  logic          err_clr;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  // model state
  logic [DW-1:0] exp_rd;
  logic [1:0]    exp_err;
  int            exp_hs;

  dmi_core_req_buffer #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .reg_en(reg_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_req_we(dm_req_we),
    .dm_req_addr(dm_req_addr), .dm_req_wdata(dm_req_wdata),
    .dm_rsp_valid(dm_rsp_valid), .dm_rsp_rdata(dm_rsp_rdata), .dm_rsp_err(dm_rsp_err),
    .rd_data(rd_data), .busy(busy), .err_status(err_status), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // count every valid/ready handshake seen on the request channel
  always @(posedge clk) begin
    if (rst_n && dm_req_valid && dm_req_ready) hs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_en = 0; reg_wr_en = 0; dm_req_ready = 0;
    dm_rsp_valid = 0; dm_rsp_err = 0; err_clr = 0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_rd"}, rd_data, exp_rd);
    check_eq({tag, "_err"}, err_status, exp_err);
  endtask

  // One full access: capture, ready_dly wait cycles, handshake,
  // rsp_dly wait cycles, response. Optional overruns in REQ / response cycle.
  task automatic run_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int ready_dly, input int rsp_dly, input logic [DW-1:0] rdat,
                         input logic rerr, input logic ov_req, input logic ov_rsp,
                         input logic clr_rsp);
    reg_en = 1; reg_wr_en = we; reg_addr = a; reg_wdata = d;
    tick();
    reg_en = 0; reg_wr_en = 1'($urandom); reg_addr = AW'($urandom); reg_wdata = $urandom;
    check_eq("cap_valid", dm_req_valid, 1);
    check_eq("cap_busy", busy, 1);
    check_eq("cap_addr", dm_req_addr, a);
    check_eq("cap_we", dm_req_we, we);
    check_eq("cap_wdata", dm_req_wdata, d);
    for (int i = 0; i < ready_dly; i++) begin
      if (ov_req && i == 0) reg_en = 1;
      tick();
      if (ov_req && i == 0) exp_err[1] = 1'b1;
      reg_en = 0;
      check_eq("req_hold_valid", dm_req_valid, 1);
      check_eq("req_hold_addr", dm_req_addr, a);
      check_eq("req_hold_wdata", dm_req_wdata, d);
      check_status("req_hold");
    end
    // handshake, with a stray response that must be ignored
    dm_req_ready = 1;
    dm_rsp_valid = 1'($urandom); dm_rsp_rdata = $urandom; dm_rsp_err = 1'($urandom);
    tick();
    exp_hs++;
    dm_req_ready = 0; dm_rsp_valid = 0; dm_rsp_err = 0;
    check_eq("hs_valid_drop", dm_req_valid, 0);
    check_eq("hs_busy", busy, 1);
    check_status("hs");
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check_eq("rsp_wait_busy", busy, 1);
      check_eq("rsp_wait_valid", dm_req_valid, 0);
    end
    dm_rsp_valid = 1; dm_rsp_rdata = rdat; dm_rsp_err = rerr;
    err_clr = clr_rsp;
    if (ov_rsp) begin
      reg_en = 1; reg_wr_en = 1'($urandom); reg_addr = AW'($urandom); reg_wdata = $urandom;
    end
    tick();
    idle_inputs();
    exp_err = (clr_rsp ? 2'b00 : exp_err) | {ov_rsp, rerr};
    if (!we && !rerr) exp_rd = rdat;
    check_eq("done_busy", busy, 0);
    check_eq("done_valid", dm_req_valid, 0);
    check_eq("done_addr", dm_req_addr, a);
    check_eq("done_wdata", dm_req_wdata, d);
    check_status("done");
  endtask

  initial begin
    int n_to;
    idle_inputs();
    reg_addr = '0; reg_wdata = '0; dm_rsp_rdata = '0;
    rst_n = 0;
    exp_rd = '0; exp_err = 2'b00; exp_hs = 0;
    tick(); tick();
    check_eq("rst_valid", dm_req_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", dm_req_we, 0);
    check_eq("rst_addr", dm_req_addr, 0);
    check_eq("rst_wdata", dm_req_wdata, 0);
    check_status("rst");
    rst_n = 1;
    tick();

    // directed: read, write with ready held, error read, clears, overrun
    run_txn(0, 7'h11, 32'h0, 2, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    check_eq("read_rd_data", rd_data, 32'hDEADBEEF);
    run_txn(1, 7'h10, 32'h80000001, 0, 2, 32'h12345678, 0, 0, 0, 0);
    run_txn(0, 7'h22, 32'h0, 1, 0, 32'hCAFEF00D, 1, 0, 0, 0);
    check_eq("err_read", err_status, 2'b01);
    err_clr = 1; tick(); err_clr = 0; exp_err = 2'b00;
    check_status("err_clr");
    run_txn(0, 7'h23, 32'h0, 0, 1, 32'h0BADF00D, 1, 0, 0, 1);
    check_eq("err_clr_vs_set", err_status, 2'b01);
    err_clr = 1; tick(); err_clr = 0; exp_err = 2'b00;
    run_txn(1, 7'h05, 32'hA5A5A5A5, 2, 1, 32'h0, 0, 1, 1, 0);
    check_eq("overrun", err_status, 2'b10);
    // reg_en in M+1 right after an overrun response is a fresh access
    run_txn(0, 7'h06, 32'h0, 0, 0, 32'h13572468, 0, 0, 0, 0);

    // randomized accesses with idle noise between them
    for (int t = 0; t < 150; t++) begin
      int n_idle;
      n_idle = $urandom_range(0, 2);
      for (int k = 0; k < n_idle; k++) begin
        err_clr = ($urandom_range(0, 3) == 0);
        reg_wr_en = 1'($urandom);
        dm_rsp_valid = 1'($urandom); dm_rsp_rdata = $urandom; dm_rsp_err = 1'($urandom);
        tick();
        if (err_clr) exp_err = 2'b00;
        idle_inputs();
        check_eq("idle_busy", busy, 0);
        check_status("idle");
      end
      run_txn(1'($urandom), AW'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end

    // stalled request: timeout build aborts, default build keeps waiting
    reg_en = 1; reg_wr_en = 0; reg_addr = 7'h33; tick(); reg_en = 0;
`ifdef DMI_REQ_TIMEOUT_EN
    n_to = 0;
    while (busy && n_to < 40) begin
      tick();
      n_to++;
    end
    check_eq("tmo_released", busy, 0);
    check_eq("tmo_not_early", (n_to >= 8), 1);
    check_eq("tmo_valid", dm_req_valid, 0);
    exp_err[0] = 1'b1;
    check_status("tmo");
`else
    n_to = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy) n_to++;
    end
    check_eq("no_tmo_busy", n_to, 1000);
    check_eq("no_tmo_valid", dm_req_valid, 1);
    dm_req_ready = 1; tick(); dm_req_ready = 0; exp_hs++;
    dm_rsp_valid = 1; dm_rsp_rdata = 32'h600DCAFE; tick(); idle_inputs();
    exp_rd = 32'h600DCAFE;
    check_status("no_tmo_done");
`endif
    check_eq("handshake_count", hs_cnt, exp_hs);

    // async reset while in RSP
    reg_en = 1; reg_wr_en = 0; reg_addr = 7'h44; tick(); reg_en = 0;
    dm_req_ready = 1; tick(); dm_req_ready = 0;
    check_eq("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_valid", dm_req_valid, 0);
    check_eq("arst_rd", rd_data, 0);
    check_eq("arst_err", err_status, 0);
    tick();
    rst_n = 1;
    dm_rsp_valid = 1; dm_rsp_rdata = 32'hFFFF0000; tick(); idle_inputs();
    check_eq("post_rst_rd", rd_data, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
